regfile_rename: RTL and testbench
=================================

Name: regfile_rename

Overview:
- Architectural register file with rename tags. It is the consumer side of the ROB commit and search interfaces.
- Holds x0..x31 and, per register, a busy bit plus the ROB tag of the youngest in-flight producer.
- At issue it resolves rs1/rs2 to either a value or a pending ROB tag, querying the ROB for write-back values, and records rd's new producer tag.
- On commit it writes values and retires tags. On flush (`clear`) it drops all rename state.

Parameters:
ROB_WIDTH, 4, bits of a ROB entry id (ROB_SIZE = 2**ROB_WIDTH)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global stall; low = hold all state
clear  in  1  mispredict flush, sampled when rdy_in high
dec_ready  in  1  issue strobe from decoder
rs1  in  5  source register 1
rs2  in  5  source register 2
rd  in  5  destination register of issuing instruction
issue_rob_id  in  ROB_WIDTH  ROB entry allocated to the issuing instruction
val1  out  32  resolved rs1 value (valid when has_dep1=0)
dep1  out  ROB_WIDTH  producer tag of rs1 (valid when has_dep1=1)
has_dep1  out  1  rs1 still pending
val2  out  32  resolved rs2 value
dep2  out  ROB_WIDTH  producer tag of rs2
has_dep2  out  1  rs2 still pending
search_rob_id_1  out  ROB_WIDTH  ROB query tag for rs1
search_ready_1  in  1  ROB entry has result
search_val_1  in  32  ROB entry result
search_rob_id_2  out  ROB_WIDTH  ROB query tag for rs2
search_ready_2  in  1  ROB entry has result
search_val_2  in  32  ROB entry result
commit_valid  in  1  one-cycle commit strobe
commit_rob_id  in  ROB_WIDTH  committing ROB entry
commit_reg_id  in  5  committing destination
commit_val  in  32  committed value

Behaviour:
- State: `regs[32]` x 32b, `busy[32]`, `tag[32]` x ROB_WIDTH. x0 always reads 0, is never busy, and writes to it are ignored.
- Reset (`rst_in` at posedge): all `regs`, `busy` and `tag` cleared to 0. Resulting outputs: `val*`=0, `has_dep*`=0, `dep*`=0, `search_rob_id_*`=0.
- Operand resolution is combinational, zero latency, and uses pre-edge state. It is evaluated independently for rs1 and rs2, in this priority order:
  1. rs==0 -> val=0, has_dep=0.
  2. !busy[rs] -> val=regs[rs], has_dep=0.
  3. busy[rs] && commit_valid && commit_rob_id==tag[rs] -> val=commit_val, has_dep=0 (commit bypass).
  4. busy[rs] && search_ready -> val=search_val, has_dep=0.
  5. Otherwise has_dep=1, dep=tag[rs], val=0.
- `search_rob_id_n` = tag[rs_n] always.
- Same-cycle issue with rd==rs reads the old mapping, never its own tag.
- Sequential updates apply only when `rdy_in`=1; with `rdy_in`=0 all state is held.
- Commit (commit_valid && commit_reg_id!=0):
  - regs[commit_reg_id] <= commit_val, unconditionally.
  - busy cleared only if tag[commit_reg_id]==commit_rob_id; otherwise a younger producer owns the register and busy/tag stay.
- Issue (dec_ready && !clear && rd!=0): busy[rd] <= 1, tag[rd] <= issue_rob_id.
  - Issue to the same rd as a same-cycle commit: issue wins on busy/tag; the commit value is still written.
- Clear (clear=1):
  - All busy <= 0; tags are don't-care.
  - A same-cycle commit is still applied to `regs`.
  - A same-cycle issue is dropped.
- Tag wrap-around is safe: the ROB never reuses an id before commit, so tag equality is unambiguous.

Test Plan:
- Reset, then rs1=5, rs2=0 -> val1=0, val2=0, has_dep1=has_dep2=0.
- Issue rd=3 tag=2. Next cycle rs1=3, search_ready_1=0 -> has_dep1=1, dep1=2, search_rob_id_1=2. Same with search_ready_1=1, search_val_1=0x55 -> val1=0x55, has_dep1=0.
- Issue rd=4 tag=1, then rd=4 tag=6. Commit rob 1, reg 4, val 0x11 -> regs[4]=0x11, busy[4] stays 1, dep=6.
- Commit rob 6, reg 4, val 0xAB with rs2=4 in the same cycle -> val2=0xAB, has_dep2=0 (bypass). Next cycle busy[4]=0, val2=0xAB.
- Issue rd=7 tag=3 and commit reg 7 (rob 0, val 9) in the same cycle -> regs[7]=9, busy[7]=1, tag[7]=3.
- Busy x1,x2, then clear with dec_ready (rd=8) and commit reg 1 val 0x77 -> all busy 0, regs[1]=0x77, x8 not busy. Also: `rdy_in`=0 with dec_ready -> no state change.

Source files
------------

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags.
// Resolves issuing operands to a value or a pending ROB tag; commit writes values and retires tags.
module regfile_rename #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 dec_ready,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [4:0]           rd,
  input  logic [ROB_WIDTH-1:0] issue_rob_id,
  output logic [31:0]          val1,
  output logic [ROB_WIDTH-1:0] dep1,
  output logic                 has_dep1,
  output logic [31:0]          val2,
  output logic [ROB_WIDTH-1:0] dep2,
  output logic                 has_dep2,
  output logic [ROB_WIDTH-1:0] search_rob_id_1,
  input  logic                 search_ready_1,
  input  logic [31:0]          search_val_1,
  output logic [ROB_WIDTH-1:0] search_rob_id_2,
  input  logic                 search_ready_2,
  input  logic [31:0]          search_val_2,
  input  logic                 commit_valid,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic [4:0]           commit_reg_id,
  input  logic [31:0]          commit_val
);

  logic [31:0]          regs_q [32];
  logic [31:0]          regs_d [32];
  logic [31:0]          busy_q;
  logic [31:0]          busy_d;
  logic [ROB_WIDTH-1:0] tag_q  [32];
  logic [ROB_WIDTH-1:0] tag_d  [32];

  // Returns {has_dep, val}; priority: x0, idle reg, commit bypass, ROB search, pending.
  function automatic logic [32:0] resolve(
    input logic [4:0]           rs,
    input logic                 busy,
    input logic [ROB_WIDTH-1:0] tag,
    input logic [31:0]          rval,
    input logic                 s_rdy,
    input logic [31:0]          s_val,
    input logic                 c_vld,
    input logic [ROB_WIDTH-1:0] c_rob,
    input logic [31:0]          c_val
  );
    logic [32:0] res;
    if (rs == 5'd0)                 res = {1'b0, 32'd0};
    else if (!busy)                 res = {1'b0, rval};
    else if (c_vld && c_rob == tag) res = {1'b0, c_val};
    else if (s_rdy)                 res = {1'b0, s_val};
    else                            res = {1'b1, 32'd0};
    return res;
  endfunction

  logic [32:0] res1;
  logic [32:0] res2;

  always_comb begin
    res1 = resolve(rs1, busy_q[rs1], tag_q[rs1], regs_q[rs1], search_ready_1, search_val_1,
                   commit_valid, commit_rob_id, commit_val);
    res2 = resolve(rs2, busy_q[rs2], tag_q[rs2], regs_q[rs2], search_ready_2, search_val_2,
                   commit_valid, commit_rob_id, commit_val);
  end

  assign has_dep1        = res1[32];
  assign val1            = res1[31:0];
  assign dep1            = res1[32] ? tag_q[rs1] : '0;
  assign has_dep2        = res2[32];
  assign val2            = res2[31:0];
  assign dep2            = res2[32] ? tag_q[rs2] : '0;
  assign search_rob_id_1 = tag_q[rs1];
  assign search_rob_id_2 = tag_q[rs2];

  // Commit first so a same-cycle issue to the same rd overrides busy/tag.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_valid && commit_reg_id != 5'd0) begin
      regs_d[commit_reg_id] = commit_val;
      if (tag_q[commit_reg_id] == commit_rob_id) busy_d[commit_reg_id] = 1'b0;
    end
    if (clear) begin
      busy_d = '0;
    end else if (dec_ready && rd != 5'd0) begin
      busy_d[rd] = 1'b1;
      tag_d[rd]  = issue_rob_id;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      busy_q <= busy_d;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Scoreboard bench for regfile_rename: directed scenarios followed by a model-driven random run.
module tb_regfile_rename;
  localparam int RW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clear, dec_ready;
  logic [4:0]    rs1, rs2, rd;
  logic [RW-1:0] issue_rob_id;
  logic [31:0]   val1, val2;
  logic [RW-1:0] dep1, dep2;
  logic          has_dep1, has_dep2;
  logic [RW-1:0] search_rob_id_1, search_rob_id_2;
  logic          search_ready_1, search_ready_2;
  logic [31:0]   search_val_1, search_val_2;
  logic          commit_valid;
  logic [RW-1:0] commit_rob_id;
  logic [4:0]    commit_reg_id;
  logic [31:0]   commit_val;

  regfile_rename #(.ROB_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .dec_ready(dec_ready), .rs1(rs1), .rs2(rs2), .rd(rd), .issue_rob_id(issue_rob_id),
    .val1(val1), .dep1(dep1), .has_dep1(has_dep1),
    .val2(val2), .dep2(dep2), .has_dep2(has_dep2),
    .search_rob_id_1(search_rob_id_1), .search_ready_1(search_ready_1), .search_val_1(search_val_1),
    .search_rob_id_2(search_rob_id_2), .search_ready_2(search_ready_2), .search_val_2(search_val_2),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .commit_reg_id(commit_reg_id), .commit_val(commit_val)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0]   v1;
    logic          h1;
    logic [RW-1:0] d1;
    logic [31:0]   v2;
    logic          h2;
    logic [RW-1:0] d2;
    logic [RW-1:0] s1;
    logic [RW-1:0] s2;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state for the random phase.
  logic [31:0]   m_regs [32];
  logic          m_busy [32];
  logic [RW-1:0] m_tag  [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] v1, input logic h1, input logic [RW-1:0] d1,
                              input logic [31:0] v2, input logic h2, input logic [RW-1:0] d2,
                              input logic [RW-1:0] s1, input logic [RW-1:0] s2);
    exp_t e;
    e.v1 = v1; e.h1 = h1; e.d1 = d1; e.v2 = v2; e.h2 = h2; e.d2 = d2; e.s1 = s1; e.s2 = s2;
    return e;
  endfunction

  task automatic next();
    @(negedge clk_in);
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; dec_ready = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; issue_rob_id = '0;
    search_ready_1 = 1'b0; search_val_1 = '0; search_ready_2 = 1'b0; search_val_2 = '0;
    commit_valid = 1'b0; commit_rob_id = '0; commit_reg_id = 5'd0; commit_val = '0;
  endtask

  // Push the expectation for the current inputs, let outputs settle, then pop and compare.
  task automatic expect_out(input string tag, input exp_t e);
    exp_t o;
    exp_q.push_back(e);
    #2;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
      return;
    end
    o = exp_q.pop_front();
    check({tag, "_val1"}, val1, o.v1);
    check({tag, "_has1"}, {31'd0, has_dep1}, {31'd0, o.h1});
    check({tag, "_dep1"}, {28'd0, dep1}, {28'd0, o.d1});
    check({tag, "_val2"}, val2, o.v2);
    check({tag, "_has2"}, {31'd0, has_dep2}, {31'd0, o.h2});
    check({tag, "_dep2"}, {28'd0, dep2}, {28'd0, o.d2});
    check({tag, "_sid1"}, {28'd0, search_rob_id_1}, {28'd0, o.s1});
    check({tag, "_sid2"}, {28'd0, search_rob_id_2}, {28'd0, o.s2});
  endtask

  function automatic void m_resolve(input logic [4:0] rs, input logic sr, input logic [31:0] sv,
                                    output logic [31:0] v, output logic h, output logic [RW-1:0] d);
    v = 32'd0; h = 1'b0; d = '0;
    if (rs == 5'd0) return;
    if (!m_busy[rs]) begin v = m_regs[rs]; return; end
    if (commit_valid && commit_rob_id == m_tag[rs]) begin v = commit_val; return; end
    if (sr) begin v = sv; return; end
    h = 1'b1;
    d = m_tag[rs];
  endfunction

  function automatic exp_t m_predict();
    exp_t e;
    m_resolve(rs1, search_ready_1, search_val_1, e.v1, e.h1, e.d1);
    m_resolve(rs2, search_ready_2, search_val_2, e.v2, e.h2, e.d2);
    e.s1 = m_tag[rs1];
    e.s2 = m_tag[rs2];
    return e;
  endfunction

  function automatic void m_update();
    logic retire;
    if (!rdy_in) return;
    retire = commit_valid && commit_reg_id != 5'd0 && m_tag[commit_reg_id] == commit_rob_id;
    if (commit_valid && commit_reg_id != 5'd0) m_regs[commit_reg_id] = commit_val;
    if (retire) m_busy[commit_reg_id] = 1'b0;
    if (clear) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else if (dec_ready && rd != 5'd0) begin
      m_busy[rd] = 1'b1;
      m_tag[rd]  = issue_rob_id;
    end
  endfunction

  initial begin
    next(); rst_in = 1'b1;
    next(); rst_in = 1'b1;

    // Reset state
    next(); rs1 = 5'd5; rs2 = 5'd0;
    expect_out("reset", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Issue rd=3 tag=2, then resolve via search
    next(); dec_ready = 1'b1; rd = 5'd3; issue_rob_id = 4'd2;
    next(); rs1 = 5'd3;
    expect_out("pend3", mk(0, 1, 2, 0, 0, 0, 2, 0));
    next(); rs1 = 5'd3; search_ready_1 = 1'b1; search_val_1 = 32'h55;
    expect_out("search3", mk(32'h55, 0, 0, 0, 0, 0, 2, 0));

    // Younger producer keeps ownership when an older one commits
    next(); dec_ready = 1'b1; rd = 5'd4; issue_rob_id = 4'd1;
    next(); dec_ready = 1'b1; rd = 5'd4; issue_rob_id = 4'd6;
    next(); commit_valid = 1'b1; commit_rob_id = 4'd1; commit_reg_id = 5'd4; commit_val = 32'h11;
    rs1 = 5'd4;
    expect_out("oldcommit", mk(0, 1, 6, 0, 0, 0, 6, 0));
    next(); rs1 = 5'd4;
    expect_out("stillbusy4", mk(0, 1, 6, 0, 0, 0, 6, 0));

    // Commit bypass, then retired
    next(); commit_valid = 1'b1; commit_rob_id = 4'd6; commit_reg_id = 5'd4; commit_val = 32'hAB;
    rs2 = 5'd4;
    expect_out("bypass4", mk(0, 0, 0, 32'hAB, 0, 0, 0, 6));
    next(); rs2 = 5'd4;
    expect_out("retired4", mk(0, 0, 0, 32'hAB, 0, 0, 0, 6));

    // Same-cycle issue and commit to x7: issue owns busy/tag, value still written
    next(); dec_ready = 1'b1; rd = 5'd7; issue_rob_id = 4'd3;
    commit_valid = 1'b1; commit_rob_id = 4'd0; commit_reg_id = 5'd7; commit_val = 32'd9;
    next(); rs1 = 5'd7;
    expect_out("issuewins7", mk(0, 1, 3, 0, 0, 0, 3, 0));

    // Issue reading its own rd sees the old mapping
    next(); dec_ready = 1'b1; rd = 5'd4; issue_rob_id = 4'd5; rs1 = 5'd4;
    expect_out("selfread", mk(32'hAB, 0, 0, 0, 0, 0, 6, 0));

    // Clear with busy x1,x2, plus issue (dropped) and commit (applied)
    next(); dec_ready = 1'b1; rd = 5'd1; issue_rob_id = 4'd4;
    next(); dec_ready = 1'b1; rd = 5'd2; issue_rob_id = 4'd5;
    next(); rs1 = 5'd1; rs2 = 5'd2;
    expect_out("busy12", mk(0, 1, 4, 0, 1, 5, 4, 5));
    next(); clear = 1'b1; dec_ready = 1'b1; rd = 5'd8; issue_rob_id = 4'd7;
    commit_valid = 1'b1; commit_rob_id = 4'd9; commit_reg_id = 5'd1; commit_val = 32'h77;
    next(); rs1 = 5'd1; rs2 = 5'd2;
    expect_out("clear12", mk(32'h77, 0, 0, 0, 0, 0, 4, 5));
    next(); rs1 = 5'd8; rs2 = 5'd7;
    expect_out("clear87", mk(0, 0, 0, 32'd9, 0, 0, 0, 3));
    next(); rs1 = 5'd3; rs2 = 5'd4;
    expect_out("clear34", mk(0, 0, 0, 32'hAB, 0, 0, 2, 5));

    // Stall holds everything; x0 writes ignored
    next(); rdy_in = 1'b0; dec_ready = 1'b1; rd = 5'd5; issue_rob_id = 4'd4;
    commit_valid = 1'b1; commit_rob_id = 4'd0; commit_reg_id = 5'd6; commit_val = 32'h123;
    next(); rs1 = 5'd5; rs2 = 5'd6;
    expect_out("stall", mk(0, 0, 0, 0, 0, 0, 0, 0));
    next(); dec_ready = 1'b1; rd = 5'd0; issue_rob_id = 4'd3;
    commit_valid = 1'b1; commit_reg_id = 5'd0; commit_val = 32'h5;
    next(); rs1 = 5'd0; rs2 = 5'd0;
    expect_out("x0", mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Random phase against the reference model
    next(); rst_in = 1'b1;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
    for (int n = 0; n < 400; n++) begin
      next();
      rdy_in         = ($urandom_range(0, 9) != 0);
      clear          = ($urandom_range(0, 19) == 0);
      dec_ready      = $urandom_range(0, 1);
      rd             = 5'($urandom_range(0, 7));
      issue_rob_id   = RW'($urandom);
      rs1            = 5'($urandom_range(0, 7));
      rs2            = 5'($urandom_range(0, 7));
      search_ready_1 = ($urandom_range(0, 3) == 0);
      search_val_1   = $urandom;
      search_ready_2 = ($urandom_range(0, 3) == 0);
      search_val_2   = $urandom;
      commit_valid   = $urandom_range(0, 1);
      commit_rob_id  = RW'($urandom);
      commit_reg_id  = 5'($urandom_range(0, 7));
      commit_val     = $urandom;
      expect_out("rand", m_predict());
      m_update();
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
